// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: the scanner has priority, the CPU has a bounded wait,
// and a displaced video fetch is replayed from a one-entry buffer.
module vram_arbiter #(
  parameter int AW           = 13,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUED, ST_DATA, ST_ACK} cpu_st_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU_RD, TAG_CPU_WR} tag_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? LIMIT : v + 4'd1;
  endfunction

  cpu_st_t       cpu_st;
  tag_t          tag_p1, tag_p2;
  logic [3:0]    starve;
  logic          pend_vld;
  logic [AW-1:0] pend_addr;

  logic cpu_cand, force_cpu, gnt_pend, gnt_vid, gnt_cpu, displace;

  // Grant stage (cycle C): pending video > forced CPU > video > CPU
  always_comb begin
    cpu_cand  = (cpu_st == ST_IDLE) & cpu_req;
    force_cpu = cpu_cand & (starve == LIMIT);
    gnt_pend  = pend_vld;
    gnt_vid   = ~pend_vld & ~force_cpu & vid_req;
    gnt_cpu   = ~pend_vld & (force_cpu | (~vid_req & cpu_cand));
    displace  = vid_req & ~gnt_vid;
  end

  assign cpu_wait = cpu_req & ~cpu_ack;

  // Address stage (C+1): winner's request registered onto the RAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      tag_p1    <= TAG_NONE;
    end else begin
      // The pending slot is always drained in the same cycle a new displacement can occur
      pend_vld <= displace;
      if (displace) pend_addr <= vid_addr;
      mem_we <= gnt_cpu & cpu_we;
      if (gnt_pend) begin
        mem_addr <= pend_addr;
        tag_p1   <= TAG_VID;
      end else if (gnt_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        tag_p1    <= cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      end else if (gnt_vid) begin
        mem_addr <= vid_addr;
        tag_p1   <= TAG_VID;
      end else begin
        tag_p1 <= TAG_NONE;
      end
    end
  end

  // Data stage (C+2): RAM output captured, completion pulses follow in C+3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_p2    <= TAG_NONE;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      tag_p2    <= tag_p1;
      vid_valid <= (tag_p2 == TAG_VID);
      if (tag_p2 == TAG_VID) vid_data <= mem_rdata;
      cpu_ack <= (tag_p2 == TAG_CPU_RD) | (tag_p1 == TAG_CPU_WR);
      if (tag_p2 == TAG_CPU_RD) cpu_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_st <= ST_IDLE;
      starve <= '0;
    end else begin
      case (cpu_st)
        ST_IDLE:   if (gnt_cpu) cpu_st <= ST_ISSUED;
        ST_ISSUED: cpu_st <= (tag_p1 == TAG_CPU_WR) ? ST_ACK : ST_DATA;
        ST_DATA:   cpu_st <= ST_ACK;
        default:   cpu_st <= ST_IDLE;
      endcase
      if (gnt_cpu || !cpu_req) starve <= '0;
      else if (cpu_cand)       starve <= sat_inc(starve);
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: per-cycle stimulus tables, a CPU requester
// that holds cpu_req until ack, a synchronous RAM model and per-cycle output logs.
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_data;
  logic          vid_valid;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_ack, cpu_wait;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata, mem_rdata;

  vram_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus tables
  logic          s_vr  [N];
  logic [AW-1:0] s_va  [N];
  logic          s_rst [N];
  int            op_start [16];
  logic          op_we    [16];
  logic [AW-1:0] op_addr  [16];
  logic [7:0]    op_wd    [16];
  int            nops, opi;
  logic          active, prev_ack;

  // output logs
  logic          l_vv [N], l_ack [N], l_wait [N], l_mwe [N];
  logic [7:0]    l_vd [N], l_crd [N], l_mwd [N];
  logic [AW-1:0] l_ma [N];

  task automatic clear();
    for (int k = 0; k < N; k++) begin
      s_vr[k] = 1'b0; s_va[k] = '0; s_rst[k] = 1'b1;
    end
    nops = 0; opi = 0; active = 1'b0; prev_ack = 1'b0;
  endtask

  task automatic add_op(input int st, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    op_start[nops] = st; op_we[nops] = we; op_addr[nops] = a; op_wd[nops] = d;
    nops++;
  endtask

  // Each iteration is one clock cycle k, entered 1 time unit after its rising edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      if (active && prev_ack) begin active = 1'b0; opi++; end
      if (!s_rst[k] && active) begin active = 1'b0; opi++; end
      if (!active && opi < nops && op_start[opi] <= k && s_rst[k]) active = 1'b1;
      rst_n    = s_rst[k];
      vid_req  = s_vr[k];
      vid_addr = s_va[k];
      cpu_req  = active;
      cpu_we   = active ? op_we[opi] : 1'b0;
      cpu_addr = active ? op_addr[opi] : '0;
      cpu_wdata = active ? op_wd[opi] : '0;
      #2;
      l_vv[k] = vid_valid; l_vd[k] = vid_data; l_ack[k] = cpu_ack; l_wait[k] = cpu_wait;
      l_crd[k] = cpu_rdata; l_ma[k] = mem_addr; l_mwe[k] = mem_we; l_mwd[k] = mem_wdata;
      prev_ack = cpu_ack;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int cnt, nv;
    rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ram[13'h1ABC] = 8'h3C;
    ram[13'h0200] = 8'h11;
    ram[13'h0300] = 8'h22;
    for (int i = 0; i < 12; i++) ram[13'h1000 + i] = 8'h40 + 8'(i);
    for (int i = 0; i < 40; i++) ram[13'h1800 + i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 8; i++)  ram[13'h0400 + i] = 8'h60 + 8'(i);
    #3;
    check("rst_vv",  vid_valid, 0);
    check("rst_ack", cpu_ack, 0);
    check("rst_ma",  mem_addr, 0);
    check("rst_mwe", mem_we, 0);
    check("rst_mwd", mem_wdata, 0);
    check("rst_vd",  vid_data, 0);
    check("rst_crd", cpu_rdata, 0);
    @(posedge clk); @(posedge clk); #1;

    // video only
    clear();
    s_vr[10] = 1'b1; s_va[10] = 13'h1ABC;
    run(16);
    check("v_ma11", l_ma[11], 13'h1ABC);
    check("v_vv12", l_vv[12], 0);
    check("v_vv13", l_vv[13], 1);
    check("v_vd13", l_vd[13], 8'h3C);
    check("v_vv14", l_vv[14], 0);

    // CPU write then read
    clear();
    add_op(2, 1'b1, 13'h0123, 8'h5A);
    add_op(2, 1'b0, 13'h0123, 8'h00);
    run(12);
    check("w_mwe2",  l_mwe[2], 0);
    check("w_mwe3",  l_mwe[3], 1);
    check("w_ma3",   l_ma[3], 13'h0123);
    check("w_mwd3",  l_mwd[3], 8'h5A);
    check("w_mwe4",  l_mwe[4], 0);
    check("w_ack3",  l_ack[3], 0);
    check("w_ack4",  l_ack[4], 1);
    check("w_wait2", l_wait[2], 1);
    check("w_wait3", l_wait[3], 1);
    check("w_wait4", l_wait[4], 0);
    check("r_ma6",   l_ma[6], 13'h0123);
    check("r_mwe6",  l_mwe[6], 0);
    check("r_ack7",  l_ack[7], 0);
    check("r_ack8",  l_ack[8], 1);
    check("r_crd8",  l_crd[8], 8'h5A);

    // collision: video wins, CPU next cycle
    clear();
    s_vr[3] = 1'b1; s_va[3] = 13'h0200;
    add_op(3, 1'b0, 13'h0300, 8'h00);
    run(12);
    check("c_ma4",   l_ma[4], 13'h0200);
    check("c_ma5",   l_ma[5], 13'h0300);
    check("c_vv6",   l_vv[6], 1);
    check("c_vd6",   l_vd[6], 8'h11);
    check("c_ack6",  l_ack[6], 0);
    check("c_wait6", l_wait[6], 1);
    check("c_ack7",  l_ack[7], 1);
    check("c_crd7",  l_crd[7], 8'h22);

    // starvation: forced CPU grant at cycle 4, video replayed afterwards
    clear();
    for (int k = 0; k < 12; k++) begin s_vr[k] = 1'b1; s_va[k] = 13'h1000 + 13'(k); end
    add_op(0, 1'b0, 13'h0300, 8'h00);
    run(20);
    check("s_ma4",   l_ma[4], 13'h1003);
    check("s_ma5",   l_ma[5], 13'h0300);
    check("s_ma6",   l_ma[6], 13'h1004);
    check("s_wait6", l_wait[6], 1);
    check("s_ack6",  l_ack[6], 0);
    check("s_ack7",  l_ack[7], 1);
    check("s_crd7",  l_crd[7], 8'h22);
    check("s_vv6",   l_vv[6], 1);
    check("s_vv7",   l_vv[7], 0);
    check("s_vv8",   l_vv[8], 1);
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      if (l_vv[k]) begin
        check($sformatf("s_vd%0d", nv), l_vd[k], 8'h40 + 8'(nv));
        nv++;
      end
    end
    check("s_nvalid", nv, 12);

    // scanner pattern with back-to-back CPU reads
    clear();
    for (int k = 0; k < 40; k++) begin
      if ((k % 16) == 0 || (k % 16) == 2) begin s_vr[k] = 1'b1; s_va[k] = 13'h1800 + 13'(k); end
    end
    for (int i = 0; i < 8; i++) add_op(0, 1'b0, 13'h0400 + 13'(i), 8'h00);
    run(40);
    for (int k = 0; k < 36; k++) begin
      if (s_vr[k]) begin
        check($sformatf("p_vv%0d", k + 3), l_vv[k + 3], 1);
        check($sformatf("p_vd%0d", k + 3), l_vd[k + 3], 8'(k) ^ 8'hA5);
      end
    end
    cnt = 0; nv = 0;
    for (int k = 0; k < 40; k++) begin
      if (l_vv[k]) nv++;
      if (l_ack[k]) begin
        check($sformatf("p_crd%0d", cnt), l_crd[k], 8'h60 + 8'(cnt));
        cnt++;
      end
    end
    check("p_nvalid", nv, 6);
    check("p_nack", cnt, 8);
    check("p_ack32", l_ack[32], 1);

    // reset during CPU read DATA state
    clear();
    add_op(2, 1'b0, 13'h0300, 8'h00);
    add_op(10, 1'b0, 13'h0123, 8'h00);
    s_rst[4] = 1'b0; s_rst[5] = 1'b0;
    run(18);
    check("x_ma3",   l_ma[3], 13'h0300);
    check("x_ma4",   l_ma[4], 0);
    check("x_mwe4",  l_mwe[4], 0);
    check("x_mwd4",  l_mwd[4], 0);
    check("x_vv4",   l_vv[4], 0);
    check("x_vd4",   l_vd[4], 0);
    check("x_ack4",  l_ack[4], 0);
    check("x_crd4",  l_crd[4], 0);
    check("x_wait4", l_wait[4], 0);
    cnt = 0;
    for (int k = 4; k < 13; k++) if (l_ack[k]) cnt++;
    check("x_noack", cnt, 0);
    check("x_ma11",  l_ma[11], 13'h0123);
    check("x_ack13", l_ack[13], 1);
    check("x_crd13", l_crd[13], 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single port of the 8 KB synchronous video RAM and shares it between the raster scanner (display fetches) and the CPU bus (KR580/Z80 reads and writes).
- The scanner has priority, so display timing stays fixed.
- A starvation counter guarantees the CPU bounded wait. A displaced video fetch is held in a one-entry buffer and replayed.
- Sits between the video generator, the CPU memory decoder and the video RAM. Runs on the 25 MHz pixel clock.

Parameters:
- AW, 13, video RAM address width.
- STARVE_LIMIT, 4, blocked CPU cycles before a forced CPU grant (range 1..15).

Ports:
- clk  in  1  pixel clock, 25 MHz.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- vid_req  in  1  one-cycle fetch strobe from the scanner.
- vid_addr  in  AW  fetch address, valid with vid_req.
- vid_data  out  8  fetched byte, registered.
- vid_valid  out  1  one-cycle pulse; vid_data valid.
- cpu_req  in  1  level; held until cpu_ack.
- cpu_we  in  1  1 = write; stable while cpu_req is high.
- cpu_addr  in  AW  CPU address; stable while cpu_req is high.
- cpu_wdata  in  8  CPU write data; stable while cpu_req is high.
- cpu_rdata  out  8  CPU read data, registered.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_wait  out  1  combinational: cpu_req & ~cpu_ack. Drives CPU WAIT.
- mem_addr  out  AW  RAM address, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_wdata  out  8  RAM write data, registered.
- mem_rdata  in  8  RAM read data, valid in the cycle after the address is presented.

Behaviour:
- Reset values (async): all outputs 0. Pending buffer empty. Starve counter 0. CPU FSM IDLE. Pipeline tags NONE.
- Grant cycle C: exactly one port owner per cycle, chosen with this priority:
  1. Pending video entry.
  2. Forced CPU (FSM IDLE, cpu_req=1, starve==STARVE_LIMIT).
  3. vid_req.
  4. CPU (FSM IDLE, cpu_req=1).
- Issue: the winner's address, we and wdata are registered into mem_* and presented in C+1. With no winner, mem_we=0 and mem_addr holds its value.
- Displaced video: a vid_req that loses in cycle C (to pending or forced CPU) is stored in pending and wins in C+1. A pending entry is never overwritten before issue.
- Pipeline tags: tag shifts from the stage presenting the address (C+1) to the data stage (C+2).
  - VID at data stage: vid_data<=mem_rdata and vid_valid=1 in C+3.
  - CPU_RD at data stage: cpu_rdata<=mem_rdata and cpu_ack=1 in C+3.
  - CPU_WR at address stage: cpu_ack=1 in C+2. mem_we is high for exactly one cycle.
- Latency: video grant-to-valid is 3 cycles, or 4 cycles if displaced. One vid_valid per vid_req, strictly in order.
- CPU FSM:
  - IDLE -> ISSUED on grant.
  - ISSUED -> ACK for a write; ISSUED -> DATA -> ACK for a read.
  - ACK -> IDLE.
  - cpu_req is ignored outside IDLE and in the ACK cycle. The requester drops cpu_req on the edge where it sees ack. cpu_req high in IDLE is a new request.
- Starve counter:
  - Increments each cycle the FSM is IDLE with cpu_req=1 and no grant. Saturates at STARVE_LIMIT.
  - Clears on CPU grant or when cpu_req=0.
  - Worst-case CPU wait is STARVE_LIMIT+1 cycles from request to grant.
- Video fetches never block a CPU transaction already in flight; the port is consumed only in the grant cycle.
- Reset mid-operation clears everything. No ack or valid pulse for an in-flight operation appears after reset release.

Test Plan:
- Video only: vid_req, vid_addr=0x1ABC in cycle 10 with RAM model holding 0x3C -> mem_addr=0x1ABC in cycle 11; vid_valid=1, vid_data=0x3C in cycle 13 only.
- CPU write then read: write 0x0123<-0x5A granted in cycle C -> mem_we=1 in C+1 only; cpu_ack in C+2; cpu_wait high C..C+1. Following read of 0x0123 -> cpu_rdata=0x5A with ack 3 cycles after its grant.
- Collision: cpu_req read and vid_req in the same cycle C -> video wins, vid_valid at C+3; CPU granted C+1, cpu_ack C+4.
- Starvation: vid_req high every cycle, cpu_req read at cycle 0 -> starve counts 1..4; forced CPU grant at cycle 4 and that vid_req replayed at cycle 5; cpu_ack at 7; every vid_req gets exactly one in-order vid_valid.
- Scanner pattern (vid_req at x[3:0]=0 and 2 of every 16) with back-to-back CPU reads -> CPU served in all other cycles; zero displaced video fetches.
- rst_n low during CPU read in the DATA state -> all outputs 0 immediately; no cpu_ack after release; next request completes normally.
